// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame scheduler: FSM encoding, default geometry
// and counter widths.
package frame_sched_pkg;

    localparam int DEF_COLS    = 1040;
    localparam int DEF_ROWS    = 4;
    localparam int DEF_OH_COLS = 16;
    localparam int DEF_DATA_W  = 8;

    localparam int ROW_W   = 2;
    localparam int COL_W   = 11;
    localparam int FRM_W   = 16;
    localparam int STUFF_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/frame_sched_if.sv
// Stream bundle for the frame scheduler: overhead source, payload source and
// framed output, all valid-ready. The scheduler takes the slave side.
interface frame_sched_if
    import frame_sched_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] i_oh_data;
    logic              i_oh_valid;
    logic              o_oh_ready;
    logic [DATA_W-1:0] i_pl_data;
    logic              i_pl_valid;
    logic              o_pl_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;

    modport master (
        output i_oh_data, i_oh_valid, i_pl_data, i_pl_valid, i_ready,
        input  o_oh_ready, o_pl_ready, o_data, o_valid
    );

    modport slave (
        input  i_oh_data, i_oh_valid, i_pl_data, i_pl_valid, i_ready,
        output o_oh_ready, o_pl_ready, o_data, o_valid
    );
endinterface

// File: rtl/frm_pos_cnt.sv
// Row/column position counter for one frame: advances on adv, wraps at the
// end of each row and frame, and flags the last beat of the frame.
module frm_pos_cnt
    import frame_sched_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             adv,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last_beat,
    output logic             wrap
);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             col_last;

    assign col_last  = (col_q == COL_MAX);
    assign last_beat = col_last & (row_q == ROW_MAX);
    assign wrap      = adv & last_beat;
    assign row       = row_q;
    assign col       = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            if (col_last) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: muxes overhead and payload streams into fixed-geometry
// frames with zero latency. FRAME_SCHED_STUFF_EN fills starved payload with 0x00.
module frame_sched
    import frame_sched_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int OH_COLS = DEF_OH_COLS,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    frame_sched_if.slave       bus,
    output logic [ROW_W-1:0]   o_row_cnt,
    output logic [COL_W-1:0]   o_col_cnt,
    output logic               o_sof,
    output logic [FRM_W-1:0]   o_frame_cnt,
    output logic               o_busy
`ifdef FRAME_SCHED_STUFF_EN
    ,
    output logic [STUFF_W-1:0] o_stuff_cnt
`endif
);
    localparam logic [COL_W-1:0] OH_END = COL_W'(OH_COLS);

    sched_state_e      state_q, state_d;
    logic              busy, sel_oh, out_valid, oh_ready, pl_ready, xfer;
    logic              last_beat, frame_wrap;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [FRM_W-1:0]  frame_cnt_q, frame_cnt_d;
`ifdef FRAME_SCHED_STUFF_EN
    logic               stuffing;
    logic [STUFF_W-1:0] stuff_cnt_q, stuff_cnt_d;
`endif

    // Position is held at zero while idle so every run starts a fresh frame.
    frm_pos_cnt #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_pos (
        .clk       (i_clk),
        .srst      (i_rst),
        .clr       (~busy),
        .adv       (xfer),
        .row       (row),
        .col       (col),
        .last_beat (last_beat),
        .wrap      (frame_wrap)
    );

    always_comb begin
        busy      = (state_q != ST_IDLE);
        sel_oh    = (col < OH_END);
        out_valid = 1'b0;
        out_data  = '0;
        oh_ready  = 1'b0;
        pl_ready  = 1'b0;
`ifdef FRAME_SCHED_STUFF_EN
        stuffing  = 1'b0;
`endif
        if (busy) begin
            if (sel_oh) begin
                out_valid = bus.i_oh_valid;
                out_data  = bus.i_oh_data;
                oh_ready  = bus.i_ready;
            end else begin
`ifdef FRAME_SCHED_STUFF_EN
                if (bus.i_pl_valid) begin
                    out_valid = 1'b1;
                    out_data  = bus.i_pl_data;
                    pl_ready  = bus.i_ready;
                end else begin
                    out_valid = 1'b1;
                    stuffing  = 1'b1;
                end
`else
                out_valid = bus.i_pl_valid;
                out_data  = bus.i_pl_data;
                pl_ready  = bus.i_ready;
`endif
            end
        end
        xfer = out_valid & bus.i_ready;
    end

    // Dropping i_en only parks the FSM in STOP; the frame still runs to its end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_en) state_d = ST_RUN;
            ST_RUN: begin
                if (!i_en) state_d = (xfer && last_beat) ? ST_IDLE : ST_STOP;
            end
            ST_STOP: begin
                if (i_en)                   state_d = ST_RUN;
                else if (xfer && last_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q + (frame_wrap ? FRM_W'(1) : FRM_W'(0));
`ifdef FRAME_SCHED_STUFF_EN
        stuff_cnt_d = stuff_cnt_q + ((xfer && stuffing) ? STUFF_W'(1) : STUFF_W'(0));
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
`ifdef FRAME_SCHED_STUFF_EN
            stuff_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef FRAME_SCHED_STUFF_EN
            stuff_cnt_q <= stuff_cnt_d;
`endif
        end
    end

    assign bus.o_valid    = out_valid;
    assign bus.o_data     = out_data;
    assign bus.o_oh_ready = oh_ready;
    assign bus.o_pl_ready = pl_ready;
    assign o_row_cnt      = row;
    assign o_col_cnt      = col;
    assign o_sof          = out_valid & (row == '0) & (col == '0);
    assign o_frame_cnt    = frame_cnt_q;
    assign o_busy         = busy;
`ifdef FRAME_SCHED_STUFF_EN
    assign o_stuff_cnt    = stuff_cnt_q;
`endif

endmodule

// File: tb/tb_frame_sched.sv
// Randomized bench for frame_sched against a position/frame model, plus a
// second tiny-geometry instance used to observe the frame counter wrap.
module tb_frame_sched;
    import frame_sched_pkg::*;

    localparam int COLS = 1040, ROWS = 4, OH_COLS = 16, DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, en = 1'b0, rst_w = 1'b1, en_w = 1'b0;
    frame_sched_if #(.DATA_W(DW)) bus ();
    frame_sched_if #(.DATA_W(DW)) bus_w ();

    logic [ROW_W-1:0] o_row_cnt, w_row;
    logic [COL_W-1:0] o_col_cnt, w_col;
    logic             o_sof, o_busy, w_sof, w_busy;
    logic [FRM_W-1:0] o_frame_cnt, w_frame;
`ifdef FRAME_SCHED_STUFF_EN
    logic [STUFF_W-1:0] o_stuff_cnt, w_stuff;
`endif

    frame_sched #(.COLS(COLS), .ROWS(ROWS), .OH_COLS(OH_COLS), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .bus(bus.slave),
        .o_row_cnt(o_row_cnt), .o_col_cnt(o_col_cnt), .o_sof(o_sof),
        .o_frame_cnt(o_frame_cnt), .o_busy(o_busy)
`ifdef FRAME_SCHED_STUFF_EN
        , .o_stuff_cnt(o_stuff_cnt)
`endif
    );

    frame_sched #(.COLS(1), .ROWS(1), .OH_COLS(1), .DATA_W(DW)) dut_w (
        .i_clk(clk), .i_rst(rst_w), .i_en(en_w), .bus(bus_w.slave),
        .o_row_cnt(w_row), .o_col_cnt(w_col), .o_sof(w_sof),
        .o_frame_cnt(w_frame), .o_busy(w_busy)
`ifdef FRAME_SCHED_STUFF_EN
        , .o_stuff_cnt(w_stuff)
`endif
    );

    int checks = 0, passes = 0;

    // Reference model: is a frame in progress, where are we, how many done.
    bit          m_active = 1'b0;
    int          m_row = 0, m_col = 0;
    logic [15:0] m_frames = '0, m_stuff = '0;
    bit          oh_taken = 1'b0, pl_taken = 1'b0;

    function automatic bit m_sel_oh();
        return m_col < OH_COLS;
    endfunction

    function automatic bit m_stuffing();
`ifdef FRAME_SCHED_STUFF_EN
        return m_active && !m_sel_oh() && !bus.i_pl_valid;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_valid();
        if (!m_active) return 1'b0;
        if (m_sel_oh()) return bus.i_oh_valid;
        return bus.i_pl_valid || m_stuffing();
    endfunction

    function automatic logic [DW-1:0] m_data();
        if (m_sel_oh()) return bus.i_oh_data;
        if (m_stuffing()) return '0;
        return bus.i_pl_data;
    endfunction

    function automatic bit m_oh_ready();
        return m_active && m_sel_oh() && bus.i_ready;
    endfunction

    function automatic bit m_pl_ready();
        return m_active && !m_sel_oh() && bus.i_ready && !m_stuffing();
    endfunction

    function automatic bit m_sof();
        return m_valid() && m_row == 0 && m_col == 0;
    endfunction

    // Clock one edge and move the model by the frame rules.
    task automatic advance();
        bit xfer, stuffed, last;
        xfer     = m_valid() && bus.i_ready;
        stuffed  = xfer && m_stuffing();
        oh_taken = m_oh_ready() && bus.i_oh_valid;
        pl_taken = m_pl_ready() && bus.i_pl_valid;
        last     = (m_row == ROWS - 1) && (m_col == COLS - 1);
        @(posedge clk);
        if (rst) begin
            m_active = 1'b0; m_row = 0; m_col = 0; m_frames = '0; m_stuff = '0;
        end else if (!m_active) begin
            m_active = en; m_row = 0; m_col = 0;
        end else if (xfer) begin
            if (stuffed) m_stuff = m_stuff + 1'b1;
            if (last) begin
                m_row = 0; m_col = 0; m_frames = m_frames + 1'b1;
                if (!en) m_active = 1'b0;
            end else if (m_col == COLS - 1) begin
                m_col = 0; m_row = m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
        #1;
    endtask

    // Sources hold a beat until it is accepted, then offer a fresh one.
    task automatic new_sources(input int oh_pct, input int pl_pct);
        if (!bus.i_oh_valid || oh_taken) begin
            bus.i_oh_valid = (int'($urandom_range(99)) < oh_pct);
            bus.i_oh_data  = DW'($urandom);
        end
        if (!bus.i_pl_valid || pl_taken) begin
            bus.i_pl_valid = (int'($urandom_range(99)) < pl_pct);
            bus.i_pl_data  = DW'($urandom);
        end
        oh_taken = 1'b0;
        pl_taken = 1'b0;
    endtask

    task automatic run_to(input int row, input int col, input int budget, output bit ok);
        int cyc = 0;
        while (!(m_active && m_row == row && m_col == col) && cyc < budget) begin
            new_sources(100, 100);
            bus.i_ready = 1'b1;
            #1;
            advance();
            cyc++;
        end
        ok = m_active && m_row == row && m_col == col;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_oh_valid = 1'b1; bus.i_pl_valid = 1'b1; bus.i_ready = 1'b1;
        bus.i_oh_data = 8'h11; bus.i_pl_data = 8'h22;
        bus_w.i_oh_valid = 1'b1; bus_w.i_oh_data = 8'h5A;
        bus_w.i_pl_valid = 1'b0; bus_w.i_pl_data = 8'h00; bus_w.i_ready = 1'b1;
        en_w = 1'b1;
        rst = 1'b1;
        advance();
        advance();
        rst = 1'b0;
        rst_w = 1'b0;
        en = 1'b0;
        #1;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.o_valid); else passes++;
        checks++; if (bus.o_oh_ready !== 1'b0) $display("FAIL reset_oh_ready got=%b exp=0", bus.o_oh_ready); else passes++;
        checks++; if (bus.o_pl_ready !== 1'b0) $display("FAIL reset_pl_ready got=%b exp=0", bus.o_pl_ready); else passes++;
        checks++; if (o_sof !== 1'b0) $display("FAIL reset_sof got=%b exp=0", o_sof); else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", o_busy); else passes++;
        checks++; if ({o_row_cnt, o_col_cnt} !== 13'd0) $display("FAIL reset_pos got=%0d/%0d exp=0/0", o_row_cnt, o_col_cnt); else passes++;
        checks++; if (o_frame_cnt !== 16'd0) $display("FAIL reset_frame got=%0d exp=0", o_frame_cnt); else passes++;
`ifdef FRAME_SCHED_STUFF_EN
        checks++; if (o_stuff_cnt !== 16'd0) $display("FAIL reset_stuff got=%0d exp=0", o_stuff_cnt); else passes++;
`endif
        advance();
        checks++; if (o_busy !== 1'b0) $display("FAIL idle_hold_busy got=%b exp=0", o_busy); else passes++;
        $display("test_reset done");
    endtask

    task automatic test_full_frame();
        int n_xfer = 0, cyc = 0, sof_seen = 0, oh_x = 0, pl_x = 0;
        en = 1'b1;
        while (n_xfer < COLS * ROWS && cyc < COLS * ROWS + 200) begin
            new_sources(100, 100);
            bus.i_ready = 1'b1;
            #1;
            checks++;
            if ({bus.o_valid, bus.o_oh_ready, bus.o_pl_ready, o_sof, o_busy} !==
                {m_valid(), m_oh_ready(), m_pl_ready(), m_sof(), m_active})
                $display("FAIL frame_ctl r%0d c%0d got=%b exp=%b", m_row, m_col,
                         {bus.o_valid, bus.o_oh_ready, bus.o_pl_ready, o_sof, o_busy},
                         {m_valid(), m_oh_ready(), m_pl_ready(), m_sof(), m_active});
            else passes++;
            if (m_valid()) begin
                checks++;
                if (bus.o_data !== m_data())
                    $display("FAIL frame_data r%0d c%0d got=%h exp=%h", m_row, m_col, bus.o_data, m_data());
                else passes++;
            end
            if (o_sof) sof_seen++;
            if (bus.o_valid && bus.i_ready) begin
                n_xfer++;
                if (bus.o_oh_ready) oh_x++;
                if (bus.o_pl_ready) pl_x++;
            end
            advance();
            cyc++;
        end
        checks++; if (n_xfer != COLS * ROWS) $display("FAIL frame_xfers got=%0d exp=%0d", n_xfer, COLS * ROWS); else passes++;
        checks++; if (sof_seen != 1) $display("FAIL frame_sof_count got=%0d exp=1", sof_seen); else passes++;
        checks++; if (oh_x != OH_COLS * ROWS) $display("FAIL frame_oh_beats got=%0d exp=%0d", oh_x, OH_COLS * ROWS); else passes++;
        checks++; if (pl_x != (COLS - OH_COLS) * ROWS) $display("FAIL frame_pl_beats got=%0d exp=%0d", pl_x, (COLS - OH_COLS) * ROWS); else passes++;
        checks++; if (o_frame_cnt !== 16'd1) $display("FAIL frame_count got=%0d exp=1", o_frame_cnt); else passes++;
        $display("test_full_frame done xfers=%0d", n_xfer);
    endtask

    task automatic test_stall();
        bit ok;
        logic [DW-1:0] d0;
        run_to(2, 500, 6000, ok);
        checks++; if (!ok) $display("FAIL stall_reach got=%0d/%0d exp=2/500", m_row, m_col); else passes++;
        new_sources(100, 100);
        d0 = bus.i_pl_data;
        for (int i = 0; i < 5; i++) begin
            bus.i_ready = 1'b0;
            new_sources(100, 100);
            #1;
            checks++;
            if ({o_row_cnt, o_col_cnt} !== {2'd2, 11'd500})
                $display("FAIL stall_pos got=%0d/%0d exp=2/500", o_row_cnt, o_col_cnt);
            else passes++;
            checks++;
            if ({bus.o_valid, bus.o_pl_ready, bus.o_data} !== {1'b1, 1'b0, d0})
                $display("FAIL stall_out got=%b%b/%h exp=10/%h", bus.o_valid, bus.o_pl_ready, bus.o_data, d0);
            else passes++;
            advance();
        end
        bus.i_ready = 1'b1;
        new_sources(100, 100);
        #1;
        checks++;
        if ({bus.o_pl_ready, bus.o_data} !== {1'b1, d0})
            $display("FAIL stall_release got=%b/%h exp=1/%h", bus.o_pl_ready, bus.o_data, d0);
        else passes++;
        advance();
        new_sources(100, 100);
        #1;
        checks++; if (o_col_cnt !== 11'd501) $display("FAIL stall_after_col got=%0d exp=501", o_col_cnt); else passes++;
        $display("test_stall done");
    endtask

    task automatic test_en_drop();
        bit ok;
        int cyc = 0;
        pulse_reset();
        en = 1'b1;
        run_to(1, 10, 2000, ok);
        checks++; if (!ok) $display("FAIL endrop_reach got=%0d/%0d exp=1/10", m_row, m_col); else passes++;
        while (m_active && cyc < 4000) begin
            en = (m_row == 2 && m_col >= 5 && m_col < 8);
            new_sources(100, 100);
            bus.i_ready = 1'b1;
            #1;
            checks++;
            if ({o_busy, o_row_cnt, o_col_cnt} !== {1'b1, 2'(m_row), 11'(m_col)})
                $display("FAIL endrop_busy got=%b %0d/%0d exp=1 %0d/%0d", o_busy, o_row_cnt, o_col_cnt, m_row, m_col);
            else passes++;
            advance();
            cyc++;
        end
        en = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0) $display("FAIL endrop_idle got=%b exp=0", o_busy); else passes++;
        checks++; if (o_frame_cnt !== 16'd1) $display("FAIL endrop_frames got=%0d exp=1", o_frame_cnt); else passes++;
        checks++; if (bus.o_valid !== 1'b0) $display("FAIL endrop_valid got=%b exp=0", bus.o_valid); else passes++;
        $display("test_en_drop done");
    endtask

    task automatic test_reset_mid();
        bit ok;
        en = 1'b1;
        run_to(3, 700, 6000, ok);
        checks++; if (!ok) $display("FAIL rstmid_reach got=%0d/%0d exp=3/700", m_row, m_col); else passes++;
        new_sources(100, 100);
        pulse_reset();
        #1;
        checks++;
        if ({o_row_cnt, o_col_cnt, o_frame_cnt} !== 29'd0)
            $display("FAIL rstmid_pos got=%0d/%0d f%0d exp=0/0 f0", o_row_cnt, o_col_cnt, o_frame_cnt);
        else passes++;
        checks++;
        if ({bus.o_valid, bus.o_oh_ready, bus.o_pl_ready, o_sof, o_busy} !== 5'b0)
            $display("FAIL rstmid_flags got=%b exp=00000", {bus.o_valid, bus.o_oh_ready, bus.o_pl_ready, o_sof, o_busy});
        else passes++;
        $display("test_reset_mid done");
    endtask

    task automatic test_stuff();
        bit ok;
        pulse_reset();
        en = 1'b1;
        run_to(0, 100, 500, ok);
        checks++; if (!ok) $display("FAIL stuff_reach got=%0d/%0d exp=0/100", m_row, m_col); else passes++;
        for (int i = 0; i < 3; i++) begin
            new_sources(100, 100);
            bus.i_pl_valid = 1'b0;
            bus.i_ready = 1'b1;
            #1;
            checks++;
`ifdef FRAME_SCHED_STUFF_EN
            if ({bus.o_valid, bus.o_pl_ready, bus.o_data} !== {1'b1, 1'b0, 8'h00})
                $display("FAIL stuff_beat got=%b%b/%h exp=10/00", bus.o_valid, bus.o_pl_ready, bus.o_data);
            else passes++;
`else
            if ({bus.o_valid, o_col_cnt} !== {1'b0, 11'd100})
                $display("FAIL starve_hold got=%b/%0d exp=0/100", bus.o_valid, o_col_cnt);
            else passes++;
`endif
            advance();
        end
        new_sources(100, 100);
        #1;
`ifdef FRAME_SCHED_STUFF_EN
        checks++; if (o_col_cnt !== 11'd103) $display("FAIL stuff_col got=%0d exp=103", o_col_cnt); else passes++;
        checks++; if (o_stuff_cnt !== 16'd3) $display("FAIL stuff_cnt got=%0d exp=3", o_stuff_cnt); else passes++;
`else
        checks++; if (o_col_cnt !== 11'd100) $display("FAIL starve_col got=%0d exp=100", o_col_cnt); else passes++;
`endif
        $display("test_stuff done");
    endtask

    task automatic test_random();
        pulse_reset();
        for (int i = 0; i < 3000; i++) begin
            en = (int'($urandom_range(99)) < 97);
            new_sources(70, 70);
            bus.i_ready = (int'($urandom_range(99)) < 75);
            #1;
            checks++;
            if ({bus.o_valid, bus.o_oh_ready, bus.o_pl_ready, o_sof, o_busy} !==
                {m_valid(), m_oh_ready(), m_pl_ready(), m_sof(), m_active})
                $display("FAIL rand_ctl r%0d c%0d got=%b exp=%b", m_row, m_col,
                         {bus.o_valid, bus.o_oh_ready, bus.o_pl_ready, o_sof, o_busy},
                         {m_valid(), m_oh_ready(), m_pl_ready(), m_sof(), m_active});
            else passes++;
            checks++;
            if ({o_row_cnt, o_col_cnt, o_frame_cnt} !== {2'(m_row), 11'(m_col), m_frames})
                $display("FAIL rand_pos got=%0d/%0d f%0d exp=%0d/%0d f%0d", o_row_cnt, o_col_cnt, o_frame_cnt, m_row, m_col, m_frames);
            else passes++;
            if (m_valid()) begin
                checks++;
                if (bus.o_data !== m_data())
                    $display("FAIL rand_data r%0d c%0d got=%h exp=%h", m_row, m_col, bus.o_data, m_data());
                else passes++;
            end
`ifdef FRAME_SCHED_STUFF_EN
            checks++;
            if (o_stuff_cnt !== m_stuff) $display("FAIL rand_stuff got=%0d exp=%0d", o_stuff_cnt, m_stuff); else passes++;
`endif
            advance();
        end
        $display("test_random done frames=%0d", m_frames);
    endtask

    task automatic test_frame_wrap();
        int cyc = 0;
        while (w_frame !== 16'hFFFF && cyc < 70000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++; if (w_frame !== 16'hFFFF) $display("FAIL wrap_reach got=%h exp=ffff", w_frame); else passes++;
        checks++;
        if ({w_sof, bus_w.o_data} !== {1'b1, 8'h5A}) $display("FAIL wrap_beat got=%b/%h exp=1/5a", w_sof, bus_w.o_data);
        else passes++;
        @(posedge clk);
        #1;
        checks++; if (w_frame !== 16'h0000) $display("FAIL wrap_zero got=%h exp=0000", w_frame); else passes++;
        $display("test_frame_wrap done");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_en_drop();
        test_reset_mid();
        test_stuff();
        test_random();
        test_frame_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
